// File: rtl/sev_seg_scan.sv
// Four-digit multiplexed seven-segment scanner with inter-digit blanking,
// frame-synchronous value loading and optional leading-zero suppression.
module sev_seg_scan #(
  parameter int unsigned DWELL = 4,
  parameter int unsigned BLANK = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_en,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  input  logic        load,
  input  logic        lz_blank,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_start
);

  typedef enum logic {StBlank, StShow} state_e;

  localparam logic [7:0] DwellLast = 8'(DWELL - 1);
  localparam logic [7:0] BlankLast = 8'(BLANK - 1);
  localparam bit         NoBlank   = (BLANK == 0);

  state_e      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] pend_val_q, pend_val_d;
  logic [3:0]  pend_dp_q, pend_dp_d;
  logic [15:0] act_val_q, act_val_d;
  logic [3:0]  act_dp_q, act_dp_d;
  logic [3:0]  an_d;
  logic [6:0]  seg_d;
  logic        dp_d;
  logic        fs_d;
  logic        enter_show;
  logic        frame;
  logic [3:0]  nib;
  logic        lead_zero;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    logic [6:0] s;
    unique case (h)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Scan sequencing: counter advances on clk_en only, clears on any transition.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    enter_show = 1'b0;
    if (clk_en) begin
      cnt_d = cnt_q + 8'd1;
      case (state_q)
        StShow: begin
          if (cnt_q == DwellLast) begin
            cnt_d = '0;
            if (NoBlank) begin
              enter_show = 1'b1;
            end else begin
              state_d = StBlank;
            end
          end
        end
        default: begin
          if (NoBlank || (cnt_q == BlankLast)) begin
            cnt_d      = '0;
            enter_show = 1'b1;
          end
        end
      endcase
    end
    if (enter_show) begin
      state_d = StShow;
      idx_d   = idx_q + 2'd1;
    end

    pend_val_d = load ? value : pend_val_q;
    pend_dp_d  = load ? dp_in : pend_dp_q;
    // A load on the boundary edge bypasses pending straight into active.
    frame      = enter_show && (idx_d == 2'd0);
    act_val_d  = frame ? pend_val_d : act_val_q;
    act_dp_d   = frame ? pend_dp_d : act_dp_q;
  end

  // Outputs are decoded from next-state so they update on the same edge.
  always_comb begin
    nib       = act_val_d[3:0];
    lead_zero = 1'b0;
    unique case (idx_d)
      2'd0: begin
        nib       = act_val_d[3:0];
        lead_zero = 1'b0;
      end
      2'd1: begin
        nib       = act_val_d[7:4];
        lead_zero = (act_val_d[15:4] == 12'h000);
      end
      2'd2: begin
        nib       = act_val_d[11:8];
        lead_zero = (act_val_d[15:8] == 8'h00);
      end
      default: begin
        nib       = act_val_d[15:12];
        lead_zero = (act_val_d[15:12] == 4'h0);
      end
    endcase

    an_d  = 4'hF;
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    fs_d  = frame;
    if (state_d == StShow) begin
      an_d  = ~(4'b0001 << idx_d);
      seg_d = (lz_blank && lead_zero) ? 7'h7F : hex_to_seg(nib);
      dp_d  = ~act_dp_d[idx_d];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StBlank;
      idx_q       <= 2'd3;
      cnt_q       <= '0;
      pend_val_q  <= '0;
      pend_dp_q   <= '0;
      act_val_q   <= '0;
      act_dp_q    <= '0;
      an          <= 4'hF;
      seg         <= 7'h7F;
      dp          <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      pend_val_q  <= pend_val_d;
      pend_dp_q   <= pend_dp_d;
      act_val_q   <= act_val_d;
      act_dp_q    <= act_dp_d;
      an          <= an_d;
      seg         <= seg_d;
      dp          <= dp_d;
      frame_start <= fs_d;
    end
  end

endmodule

// File: tb/tb_sev_seg_scan.sv
// Bench for sev_seg_scan: a pulse-schedule model checked every cycle on two
// configurations, plus directed scenarios with hand-computed literals.
module tb_sev_seg_scan;

  logic clk;
  logic [1:0]       rst, en, ld, lz;
  logic [1:0][15:0] val;
  logic [1:0][3:0]  dpi;
  logic [1:0][3:0]  an;
  logic [1:0][6:0]  seg;
  logic [1:0]       dp, fs;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  sev_seg_scan #(.DWELL(4), .BLANK(1)) u_dut0 (
    .clk(clk), .reset(rst[0]), .clk_en(en[0]), .value(val[0]), .dp_in(dpi[0]),
    .load(ld[0]), .lz_blank(lz[0]), .an(an[0]), .seg(seg[0]), .dp(dp[0]),
    .frame_start(fs[0])
  );

  sev_seg_scan #(.DWELL(1), .BLANK(0)) u_dut1 (
    .clk(clk), .reset(rst[1]), .clk_en(en[1]), .value(val[1]), .dp_in(dpi[1]),
    .load(ld[1]), .lz_blank(lz[1]), .an(an[1]), .seg(seg[1]), .dp(dp[1]),
    .frame_start(fs[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: timed out waiting at %0t", name, $time);
  endtask

  function automatic logic [6:0] dec(input logic [3:0] h);
    logic [6:0] t [16];
    t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return t[h];
  endfunction

  // Model: position in the scan is a pure function of clk_en pulses since reset.
  int          n_m   [2];
  logic [15:0] pend_m[2];
  logic [15:0] act_m [2];
  logic [3:0]  pdp_m [2];
  logic [3:0]  adp_m [2];
  bit          live  [2] = '{0, 0};
  logic [3:0]  e_an  [2];
  logic [6:0]  e_seg [2];
  logic        e_dp  [2];
  logic        e_fs  [2];

  task automatic model_step(input int k);
    int d, b, per, off, t, dig;
    logic [15:0] upper;
    d   = (k == 0) ? 4 : 1;
    b   = (k == 0) ? 1 : 0;
    per = d + b;
    off = (b == 0) ? 1 : b;
    if (rst[k]) begin
      n_m[k] = 0; pend_m[k] = '0; act_m[k] = '0; pdp_m[k] = '0; adp_m[k] = '0;
      live[k] = 1'b1;
      e_an[k] = 4'hF; e_seg[k] = 7'h7F; e_dp[k] = 1'b1; e_fs[k] = 1'b0;
    end else if (live[k]) begin
      e_fs[k] = 1'b0;
      if (en[k]) begin
        n_m[k]++;
        t = n_m[k] - off;
        if (t >= 0 && (t % (4 * per)) == 0) begin
          act_m[k] = ld[k] ? val[k] : pend_m[k];
          adp_m[k] = ld[k] ? dpi[k] : pdp_m[k];
          e_fs[k]  = 1'b1;
        end
      end
      if (ld[k]) begin
        pend_m[k] = val[k];
        pdp_m[k]  = dpi[k];
      end
      t = n_m[k] - off;
      if (t < 0 || (t % per) >= d) begin
        e_an[k] = 4'hF; e_seg[k] = 7'h7F; e_dp[k] = 1'b1;
      end else begin
        dig     = (t / per) % 4;
        e_an[k] = ~(4'b0001 << dig);
        upper   = act_m[k] >> (4 * dig);
        e_seg[k] = (lz[k] && dig > 0 && upper == 16'h0) ? 7'h7F : dec(upper[3:0]);
        e_dp[k] = ~adp_m[k][dig];
      end
    end
  endtask

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) model_step(k);
    #1;
    for (int k = 0; k < 2; k++) begin
      if (live[k]) begin
        chk($sformatf("model%0d an", k), 16'(an[k]), 16'(e_an[k]));
        chk($sformatf("model%0d seg", k), 16'(seg[k]), 16'(e_seg[k]));
        chk($sformatf("model%0d dp", k), 16'(dp[k]), 16'(e_dp[k]));
        chk($sformatf("model%0d fs", k), 16'(fs[k]), 16'(e_fs[k]));
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    cyc++;
    en[0] = (cyc % 3 == 0);
  endtask

  task automatic wait_an(input logic [3:0] want, input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (an[0] == want) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) timeout(name);
  endtask

  task automatic wait_fs(input int k, input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (fs[k] == 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout(name);
  endtask

  task automatic load0(input logic [15:0] v, input logic [3:0] d);
    val[0] = v; dpi[0] = d; ld[0] = 1'b1;
    tick();
    ld[0] = 1'b0;
  endtask

  initial begin
    int len, c0;
    rst = 2'b11; en = 2'b10; ld = 2'b00; lz = 2'b00;
    val = '0; dpi = '0;
    tick(); tick();
    chk("reset an", 16'(an[0]), 16'h000F);
    chk("reset seg", 16'(seg[0]), 16'h007F);
    chk("reset dp", 16'(dp[0]), 16'h0001);
    chk("reset fs", 16'(fs[0]), 16'h0000);

    // Release both; load immediately.
    rst = 2'b00;
    val[0] = 16'h1234; dpi[0] = 4'b0001; ld[0] = 1'b1;
    val[1] = 16'h3210; ld[1] = 1'b1;
    tick();
    ld = 2'b00;

    // Unblanked, 1-pulse dwell with clk_en tied high.
    if (fs[1] != 1'b1) wait_fs(1, "dut1 first frame");
    chk("nb an d0", 16'(an[1]), 16'h000E);
    chk("nb seg d0", 16'(seg[1]), 16'h0040);
    for (int i = 0; i < 4; i++) begin
      logic [3:0] exp_an [4];
      exp_an = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
      tick();
      chk("nb an seq", 16'(an[1]), 16'(exp_an[i]));
      chk("nb fs seq", 16'(fs[1]), (i == 3) ? 16'h1 : 16'h0);
    end

    // First frame of the default configuration.
    if (fs[0] != 1'b1) wait_fs(0, "dut0 first frame");
    c0 = cyc;
    chk("first an", 16'(an[0]), 16'h000E);
    chk("first seg", 16'(seg[0]), 16'h0019);
    chk("first dp", 16'(dp[0]), 16'h0000);
    len = 1;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (an[0] != 4'b1110) break;
      len++;
    end
    chk("lit length", 16'(len), 16'd12);
    len = 1;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (an[0] != 4'b1111) break;
      len++;
    end
    chk("blank length", 16'(len), 16'd3);
    chk("digit1 an", 16'(an[0]), 16'h000D);
    chk("digit1 seg", 16'(seg[0]), 16'h0030);
    wait_fs(0, "second frame");
    chk("frame length", 16'(cyc - c0), 16'd60);

    // Leading-zero suppression.
    lz[0] = 1'b1;
    load0(16'h0050, 4'b0000);
    wait_fs(0, "lz frame");
    chk("lz d0", 16'(seg[0]), 16'h0040);
    wait_an(4'b1101, "lz d1");
    chk("lz d1", 16'(seg[0]), 16'h0012);
    wait_an(4'b1011, "lz d2");
    chk("lz d2", 16'(seg[0]), 16'h007F);
    wait_an(4'b0111, "lz d3");
    chk("lz d3", 16'(seg[0]), 16'h007F);
    load0(16'h0000, 4'b0000);
    wait_fs(0, "zero frame");
    chk("zero d0", 16'(seg[0]), 16'h0040);
    wait_an(4'b1101, "zero d1");
    chk("zero d1", 16'(seg[0]), 16'h007F);
    lz[0] = 1'b0;

    // Mid-frame load waits for the next frame.
    load0(16'h1234, 4'b0000);
    wait_fs(0, "old frame");
    wait_an(4'b1011, "mid d2");
    load0(16'hABCD, 4'b0000);
    chk("mid d2 old", 16'(seg[0]), 16'h0024);
    wait_an(4'b0111, "mid d3");
    chk("mid d3 old", 16'(seg[0]), 16'h0079);
    wait_fs(0, "new frame");
    chk("new d0", 16'(seg[0]), 16'h0021);
    wait_an(4'b1101, "new d1");
    chk("new d1", 16'(seg[0]), 16'h0046);
    wait_an(4'b1011, "new d2");
    chk("new d2", 16'(seg[0]), 16'h0003);
    wait_an(4'b0111, "new d3");
    chk("new d3", 16'(seg[0]), 16'h0008);

    // Load landing exactly on the frame-boundary edge.
    wait_an(4'b1111, "pre-boundary blank");
    for (int i = 0; i < 10 && !en[0]; i++) tick();
    load0(16'h00E7, 4'b0001);
    chk("boundary fs", 16'(fs[0]), 16'h0001);
    chk("boundary an", 16'(an[0]), 16'h000E);
    chk("boundary seg", 16'(seg[0]), 16'h0078);
    chk("boundary dp", 16'(dp[0]), 16'h0000);

    // Reset mid-show discards a pending load.
    wait_an(4'b1101, "pre-reset d1");
    load0(16'h9999, 4'b1111);
    rst[0] = 1'b1;
    tick();
    rst[0] = 1'b0;
    chk("mid reset an", 16'(an[0]), 16'h000F);
    chk("mid reset seg", 16'(seg[0]), 16'h007F);
    chk("mid reset dp", 16'(dp[0]), 16'h0001);
    chk("mid reset fs", 16'(fs[0]), 16'h0000);
    wait_fs(0, "post-reset frame");
    chk("post reset an", 16'(an[0]), 16'h000E);
    chk("post reset seg", 16'(seg[0]), 16'h0040);
    chk("post reset dp", 16'(dp[0]), 16'h0001);
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
